data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for CPU load/store traffic. Replaces the zero-latency combinational data memory path with a valid/ready request/response handshake and configurable wait states.
- Enables later multi-cycle CPU variants and stall-driven testing.
- Implements RV32I load/store width semantics from funct3: byte lanes, sign/zero extension, and alignment and range checking.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words of storage.
- WAIT_CYCLES, 2: wait states between request acceptance and response. Range 0..15.
- ADDR_WIDTH, 32: width of the byte address input.

Ports:
- clock  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I load/store funct3
- req_endereco  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  requester consumes the response
- resp_rdata  out  32  load result after extension; 0 for stores and errors
- resp_erro  out  1  request faulted
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE. resp_valid=0, resp_rdata=0, resp_erro=0, wait counter=0.
  - req_ready is forced to 0 while reset is high.
  - Storage contents are not reset. The simulation model zero-initialises storage.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, latch write, funct3, address and wdata. Go to WAIT with counter=WAIT_CYCLES-1. If WAIT_CYCLES=0, go straight to RESP.
  - WAIT: req_ready=0. Decrement the counter. When it reaches 0, perform the access and load the response registers. Go to RESP.
  - RESP: resp_valid=1. Hold resp_rdata and resp_erro stable until resp_ready=1. On resp_ready=1, clear resp_valid and return to IDLE.
  - req_ready stays 0 in RESP. No new request is accepted in the same cycle a response is consumed.
- Latency: resp_valid rises exactly WAIT_CYCLES+1 cycles after the accepting edge.
- Stores commit to storage on the edge that enters RESP (same edge as response load).
- Word index = req_endereco[ADDR_WIDTH-1:2].
- Byte lane = req_endereco[1:0].
- Loads:
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the selected halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extend the selected byte.
  - 101 LHU: zero-extend the selected halfword.
- Stores:
  - 000 SB: write only the addressed byte.
  - 001 SH: write only the addressed halfword.
  - 010 SW: write the full word.
  - Byte lanes that are not written are unchanged.
- Error conditions (resp_erro=1, resp_rdata=0, no storage change):
  - halfword access with address[0]=1;
  - word access with address[1:0]≠0;
  - word index ≥ DEPTH_WORDS;
  - load funct3 ∈ {011, 110, 111};
  - store funct3 ∉ {000, 001, 010}.
- Store responses carry resp_rdata=0 and resp_erro=0 on success.
- Reset mid-operation:
  - Reset in WAIT aborts the request; the pending store is never committed.
  - Reset in RESP drops the response; the already-committed store persists.
- Request inputs are sampled only on the accepting edge. Later changes to them do not affect the transaction.
- busy = (state≠IDLE).

Test Plan:
- WAIT_CYCLES=2: SW 0xDEADBEEF to 0x10, then LW 0x10 -> resp_valid exactly 3 cycles after each accept; load returns 0xDEADBEEF with resp_erro=0.
- After SW 0x11223344 at 0x20: SB 0xAA to 0x21, then LW 0x20 -> 0x1122AA44. LB 0x21 -> 0xFFFFFFAA. LBU 0x21 -> 0x000000AA. LH 0x22 -> 0x00001122.
- LW 0x13 and SH 0x15 -> resp_erro=1, resp_rdata=0; a subsequent LW of words 0x10 and 0x14 shows both unchanged. Address 4*DEPTH_WORDS -> resp_erro=1.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_rdata stable, req_ready=0, a new req_valid is ignored; resp_ready=1 -> IDLE next cycle, req_ready=1.
- Reset during WAIT of SW 0x55 to 0x40 -> state IDLE, outputs zero, later LW 0x40 returns the prior value.
- WAIT_CYCLES=0: LW accepted at edge N -> resp_valid at N+1; back-to-back requests with resp_ready tied 1 -> one transaction every 2 cycles.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response handshake bundle between a load/store requester and the data memory responder.
interface data_mem_responder_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_endereco;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_erro;

    modport master (
        output req_valid, req_write, req_funct3, req_endereco, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_erro
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_endereco, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_erro
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: valid/ready load/store handshake with configurable wait states
// and RV32I byte-lane, extension, alignment and range semantics.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                clock,
    input  logic                reset,
    data_mem_responder_if.slave bus,
    output logic                busy
);
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned IDX_W     = ADDR_WIDTH - 2;
    localparam int unsigned MEM_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]            state, state_next;
    logic [CNT_W-1:0]      wait_cnt, wait_cnt_next;
    logic                  accept;
    logic                  access;

    logic                  lat_write;
    logic [2:0]            lat_funct3;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [31:0]           lat_wdata;

    logic                  acc_write;
    logic [2:0]            acc_funct3;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic [IDX_W-1:0]      acc_idx;
    logic [1:0]            acc_lane;
    logic                  acc_err;
    logic [31:0]           rd_word;
    logic [31:0]           rd_shift;
    logic [31:0]           load_data;
    logic [3:0]            wr_mask;
    logic [31:0]           wr_data;
    logic                  mem_we;

    logic [31:0] mem [DEPTH_WORDS];

    assign bus.req_ready = (state == S_IDLE) && !reset;

    // Next-state and wait-state countdown
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        accept        = 1'b0;
        access        = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        access     = 1'b1;
                        state_next = S_RESP;
                    end else begin
                        state_next    = S_WAIT;
                        wait_cnt_next = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    access     = 1'b1;
                    state_next = S_RESP;
                end else begin
                    wait_cnt_next = wait_cnt - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // With zero wait states the access uses the live request on the accepting edge
    always_comb begin
        acc_write  = accept ? bus.req_write    : lat_write;
        acc_funct3 = accept ? bus.req_funct3   : lat_funct3;
        acc_addr   = accept ? bus.req_endereco : lat_addr;
        acc_wdata  = accept ? bus.req_wdata    : lat_wdata;
        acc_idx    = acc_addr[ADDR_WIDTH-1:2];
        acc_lane   = acc_addr[1:0];

        acc_err = 1'b0;
        if (acc_idx >= IDX_W'(DEPTH_WORDS)) begin
            acc_err = 1'b1;
        end
        case (acc_funct3[1:0])
            2'b01:   if (acc_lane[0]) acc_err = 1'b1;
            2'b10:   if (acc_lane != 2'b00) acc_err = 1'b1;
            2'b11:   acc_err = 1'b1;
            default: ;
        endcase
        if (acc_funct3[2] && (acc_write || acc_funct3[1])) begin
            acc_err = 1'b1;
        end

        rd_word  = mem[acc_idx[MEM_IDX_W-1:0]];
        rd_shift = rd_word >> {acc_lane, 3'b000};
        case (acc_funct3)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, rd_shift[7:0]};
            3'b101:  load_data = {16'd0, rd_shift[15:0]};
            default: load_data = '0;
        endcase

        case (acc_funct3[1:0])
            2'b00:   wr_mask = 4'b0001 << acc_lane;
            2'b01:   wr_mask = 4'b0011 << acc_lane;
            2'b10:   wr_mask = 4'b1111;
            default: wr_mask = 4'b0000;
        endcase
        wr_data = acc_wdata << {acc_lane, 3'b000};
        mem_we  = access && acc_write && !acc_err && !reset;
    end

    // State, latched request and response registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            wait_cnt       <= '0;
            busy           <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_erro  <= 1'b0;
            lat_write      <= 1'b0;
            lat_funct3     <= '0;
            lat_addr       <= '0;
            lat_wdata      <= '0;
        end else begin
            state          <= state_next;
            wait_cnt       <= wait_cnt_next;
            busy           <= (state_next != S_IDLE);
            bus.resp_valid <= (state_next == S_RESP);
            if (accept) begin
                lat_write  <= bus.req_write;
                lat_funct3 <= bus.req_funct3;
                lat_addr   <= bus.req_endereco;
                lat_wdata  <= bus.req_wdata;
            end
            if (access) begin
                bus.resp_erro  <= acc_err;
                bus.resp_rdata <= (acc_err || acc_write) ? 32'd0 : load_data;
            end
        end
    end

    // Storage is not reset; only the addressed byte lanes are written
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem[acc_idx[MEM_IDX_W-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a 2-wait-state and a 0-wait-state instance checked every
// cycle against a byte-addressed transaction model, plus directed literal scenarios.
module tb_data_mem_responder;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 32;
    localparam int          W0    = 2;
    localparam int          W1    = 0;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic        rq_valid[2];
    logic        rq_write[2];
    logic [2:0]  rq_f3[2];
    logic [31:0] rq_a[2];
    logic [31:0] rq_wd[2];
    logic        rs_ready[2];

    logic        rq_ready_o[2];
    logic        rs_valid_o[2];
    logic        rs_erro_o[2];
    logic [31:0] rs_rdata_o[2];
    logic        busy_o[2];
    logic        busy0, busy1;

    data_mem_responder_if #(.ADDR_WIDTH(AW)) bus0 ();
    data_mem_responder_if #(.ADDR_WIDTH(AW)) bus1 ();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0), .ADDR_WIDTH(AW)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0), .busy(busy0));
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1), .ADDR_WIDTH(AW)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1), .busy(busy1));

    assign bus0.req_valid    = rq_valid[0];
    assign bus0.req_write    = rq_write[0];
    assign bus0.req_funct3   = rq_f3[0];
    assign bus0.req_endereco = rq_a[0];
    assign bus0.req_wdata    = rq_wd[0];
    assign bus0.resp_ready   = rs_ready[0];
    assign bus1.req_valid    = rq_valid[1];
    assign bus1.req_write    = rq_write[1];
    assign bus1.req_funct3   = rq_f3[1];
    assign bus1.req_endereco = rq_a[1];
    assign bus1.req_wdata    = rq_wd[1];
    assign bus1.resp_ready   = rs_ready[1];

    assign rq_ready_o[0] = bus0.req_ready;
    assign rs_valid_o[0] = bus0.resp_valid;
    assign rs_erro_o[0]  = bus0.resp_erro;
    assign rs_rdata_o[0] = bus0.resp_rdata;
    assign busy_o[0]     = busy0;
    assign rq_ready_o[1] = bus1.req_ready;
    assign rs_valid_o[1] = bus1.resp_valid;
    assign rs_erro_o[1]  = bus1.resp_erro;
    assign rs_rdata_o[1] = bus1.resp_rdata;
    assign busy_o[1]     = busy1;

    // Transaction-level model: byte-addressed little-endian storage and a per-request countdown
    logic [7:0]  m_mem[2][4*DEPTH];
    logic        m_pend[2];
    int          m_left[2];
    logic        m_rv[2];
    logic [31:0] m_rd[2];
    logic        m_er[2];
    logic        l_w[2];
    logic [2:0]  l_f3[2];
    logic [31:0] l_a[2];
    logic [31:0] l_wd[2];

    function automatic int wait_of(input int k);
        return (k == 0) ? W0 : W1;
    endfunction

    function automatic void m_access(input int k, input logic w, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic er);
        int sz;
        logic [31:0] v;
        rd = '0;
        er = 1'b0;
        v  = '0;
        case (f3[1:0])
            2'd0:    sz = 1;
            2'd1:    sz = 2;
            2'd2:    sz = 4;
            default: sz = 0;
        endcase
        if (sz == 0) er = 1'b1;
        else if (f3[2] && (w || sz == 4)) er = 1'b1;
        else if ((a % 32'(sz)) != 0) er = 1'b1;
        if ((a / 4) >= DEPTH) er = 1'b1;
        if (er) return;
        for (int b = 0; b < sz; b++) begin
            if (w) m_mem[k][a + 32'(b)] = wd[8*b +: 8];
            else   v[8*b +: 8] = m_mem[k][a + 32'(b)];
        end
        if (!w) begin
            if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
            rd = v;
        end
    endfunction

    function automatic void model_step(input int k);
        if (reset) begin
            m_pend[k] = 1'b0;
            m_rv[k]   = 1'b0;
            m_rd[k]   = '0;
            m_er[k]   = 1'b0;
        end else if (m_rv[k]) begin
            if (rs_ready[k]) m_rv[k] = 1'b0;
        end else if (m_pend[k]) begin
            m_left[k]--;
            if (m_left[k] == 0) begin
                m_access(k, l_w[k], l_f3[k], l_a[k], l_wd[k], m_rd[k], m_er[k]);
                m_pend[k] = 1'b0;
                m_rv[k]   = 1'b1;
            end
        end else if (rq_valid[k]) begin
            l_w[k]  = rq_write[k];
            l_f3[k] = rq_f3[k];
            l_a[k]  = rq_a[k];
            l_wd[k] = rq_wd[k];
            if (wait_of(k) == 0) begin
                m_access(k, l_w[k], l_f3[k], l_a[k], l_wd[k], m_rd[k], m_er[k]);
                m_rv[k] = 1'b1;
            end else begin
                m_pend[k] = 1'b1;
                m_left[k] = wait_of(k);
            end
        end
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %08h expected %08h at t=%0t", nm, k, act, exp, $time);
        end
    endtask

    // Single compare process: step the model on each edge, check both instances just after it
    always @(posedge clock) begin
        cyc++;
        for (int k = 0; k < 2; k++) model_step(k);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("req_ready", k, 32'(rq_ready_o[k]), 32'(!reset && !m_pend[k] && !m_rv[k]));
            chk("resp_valid", k, 32'(rs_valid_o[k]), 32'(m_rv[k]));
            chk("busy", k, 32'(busy_o[k]), 32'(m_pend[k] || m_rv[k]));
            if (m_rv[k]) begin
                chk("resp_rdata", k, rs_rdata_o[k], m_rd[k]);
                chk("resp_erro", k, 32'(rs_erro_o[k]), 32'(m_er[k]));
            end
        end
    end

    task automatic txn(input int k, input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input int bp, output logic [31:0] rd,
                       output logic er, output int lat, output int acc);
        int guard;
        rd  = '0;
        er  = 1'b0;
        lat = 0;
        acc = 0;
        @(negedge clock);
        rq_valid[k] = 1'b1;
        rq_write[k] = w;
        rq_f3[k]    = f3;
        rq_a[k]     = a;
        rq_wd[k]    = wd;
        rs_ready[k] = (bp == 0);
        guard = 0;
        while (!rq_ready_o[k] && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        chk("accepted", k, 32'(rq_ready_o[k]), 32'd1);
        if (!rq_ready_o[k]) begin
            rq_valid[k] = 1'b0;
            rs_ready[k] = 1'b1;
            return;
        end
        @(posedge clock);
        #1;
        acc = cyc;
        lat = 1;
        rq_valid[k] = 1'b0;
        rq_write[k] = 1'($urandom);
        rq_f3[k]    = 3'($urandom);
        rq_a[k]     = $urandom;
        rq_wd[k]    = $urandom;
        while (!rs_valid_o[k] && lat < 100) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("resp_seen", k, 32'(rs_valid_o[k]), 32'd1);
        rd = rs_rdata_o[k];
        er = rs_erro_o[k];
        if (bp > 0) begin
            repeat (bp) @(posedge clock);
            #1;
            rs_ready[k] = 1'b1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic lit(input string nm, input int k, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd;
        logic er;
        int lat, acc;
        txn(k, w, f3, a, wd, 0, rd, er, lat, acc);
        chk({nm, "_rdata"}, k, rd, exp_rd);
        chk({nm, "_erro"}, k, 32'(er), 32'(exp_er));
        chk({nm, "_latency"}, k, 32'(lat), 32'(wait_of(k) + 1));
        chk({nm, "_model"}, k, m_rd[k], exp_rd);
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic er;
        int lat, a0, a1, a2;
        logic [2:0] f3;
        logic [31:0] a;
        logic [2:0] bad_ld [3];

        for (int k = 0; k < 2; k++) begin
            rq_valid[k] = 1'b0; rq_write[k] = 1'b0; rq_f3[k] = '0;
            rq_a[k] = '0; rq_wd[k] = '0; rs_ready[k] = 1'b1;
            m_pend[k] = 1'b0; m_left[k] = 0; m_rv[k] = 1'b0; m_rd[k] = '0; m_er[k] = 1'b0;
            l_w[k] = 1'b0; l_f3[k] = '0; l_a[k] = '0; l_wd[k] = '0;
            for (int i = 0; i < 4 * DEPTH; i++) m_mem[k][i] = 8'h00;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", k, 32'(rq_ready_o[k]), 32'd0);
            chk("rst_resp_valid", k, 32'(rs_valid_o[k]), 32'd0);
            chk("rst_rdata", k, rs_rdata_o[k], 32'd0);
            chk("rst_erro", k, 32'(rs_erro_o[k]), 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;

        // Give storage defined contents in both instances
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++)
                txn(k, 1'b1, 3'b010, 32'(i * 4), $urandom, 0, rd, er, lat, a0);

        lit("sw_10", 0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        lit("lw_10", 0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        lit("sw_20", 0, 1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0);
        lit("sb_21", 0, 1'b1, 3'b000, 32'h21, 32'h123456AA, 32'h0, 1'b0);
        lit("lw_20", 0, 1'b0, 3'b010, 32'h20, 32'h0, 32'h1122AA44, 1'b0);
        lit("lb_21", 0, 1'b0, 3'b000, 32'h21, 32'h0, 32'hFFFFFFAA, 1'b0);
        lit("lbu_21", 0, 1'b0, 3'b100, 32'h21, 32'h0, 32'h000000AA, 1'b0);
        lit("lh_22", 0, 1'b0, 3'b001, 32'h22, 32'h0, 32'h00001122, 1'b0);

        lit("sw_14", 0, 1'b1, 3'b010, 32'h14, 32'h0BADF00D, 32'h0, 1'b0);
        lit("lw_13", 0, 1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1);
        lit("sh_15", 0, 1'b1, 3'b001, 32'h15, 32'hFFFFFFFF, 32'h0, 1'b1);
        lit("lw_10b", 0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        lit("lw_14", 0, 1'b0, 3'b010, 32'h14, 32'h0, 32'h0BADF00D, 1'b0);
        lit("lw_oor", 0, 1'b0, 3'b010, 32'(4 * DEPTH), 32'h0, 32'h0, 1'b1);
        lit("sw_oor", 0, 1'b1, 3'b010, 32'(4 * DEPTH), 32'h1, 32'h0, 1'b1);
        bad_ld[0] = 3'b011; bad_ld[1] = 3'b110; bad_ld[2] = 3'b111;
        for (int i = 0; i < 3; i++) lit("ld_badf3", 0, 1'b0, bad_ld[i], 32'h20, 32'h0, 32'h0, 1'b1);
        lit("st_badf3", 0, 1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1);
        lit("lw_20b", 0, 1'b0, 3'b010, 32'h20, 32'h0, 32'h1122AA44, 1'b0);

        // Backpressure: response held, competing request ignored
        @(negedge clock);
        rq_valid[0] = 1'b1; rq_write[0] = 1'b0; rq_f3[0] = 3'b010; rq_a[0] = 32'h10; rs_ready[0] = 1'b0;
        @(posedge clock);
        #1;
        rq_valid[0] = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("bp_valid", 0, 32'(rs_valid_o[0]), 32'd1);
        chk("bp_rdata", 0, rs_rdata_o[0], 32'hDEADBEEF);
        rq_valid[0] = 1'b1; rq_write[0] = 1'b1; rq_a[0] = 32'h10; rq_wd[0] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk("bp_hold_valid", 0, 32'(rs_valid_o[0]), 32'd1);
            chk("bp_hold_rdata", 0, rs_rdata_o[0], 32'hDEADBEEF);
            chk("bp_req_ready", 0, 32'(rq_ready_o[0]), 32'd0);
        end
        rq_valid[0] = 1'b0;
        rs_ready[0] = 1'b1;
        @(posedge clock);
        #1;
        chk("bp_release_valid", 0, 32'(rs_valid_o[0]), 32'd0);
        chk("bp_idle_ready", 0, 32'(rq_ready_o[0]), 32'd1);
        chk("bp_idle_busy", 0, 32'(busy_o[0]), 32'd0);
        lit("bp_lw_10", 0, 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Reset in WAIT aborts a pending store
        lit("sw_40", 0, 1'b1, 3'b010, 32'h40, 32'h12345678, 32'h0, 1'b0);
        @(negedge clock);
        rq_valid[0] = 1'b1; rq_write[0] = 1'b1; rq_f3[0] = 3'b010; rq_a[0] = 32'h40; rq_wd[0] = 32'h55;
        @(posedge clock);
        #1;
        rq_valid[0] = 1'b0;
        chk("rst_wait_busy", 0, 32'(busy_o[0]), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rstw_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("rstw_valid", 0, 32'(rs_valid_o[0]), 32'd0);
        chk("rstw_rdata", 0, rs_rdata_o[0], 32'd0);
        chk("rstw_erro", 0, 32'(rs_erro_o[0]), 32'd0);
        chk("rstw_req_ready", 0, 32'(rq_ready_o[0]), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk("rstw_ready_after", 0, 32'(rq_ready_o[0]), 32'd1);
        lit("lw_40", 0, 1'b0, 3'b010, 32'h40, 32'h0, 32'h12345678, 1'b0);

        // Reset in RESP drops the response but keeps the committed store
        @(negedge clock);
        rq_valid[0] = 1'b1; rq_write[0] = 1'b1; rq_f3[0] = 3'b010; rq_a[0] = 32'h44; rq_wd[0] = 32'h77;
        rs_ready[0] = 1'b0;
        @(posedge clock);
        #1;
        rq_valid[0] = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rstr_valid_before", 0, 32'(rs_valid_o[0]), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("rstr_valid", 0, 32'(rs_valid_o[0]), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rs_ready[0] = 1'b1;
        lit("lw_44", 0, 1'b0, 3'b010, 32'h44, 32'h0, 32'h00000077, 1'b0);

        // Zero wait states: one-cycle latency and a transaction every two cycles
        lit("w0_sw_10", 1, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0);
        lit("w0_lw_10", 1, 1'b0, 3'b010, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);
        lit("w0_lhu_12", 1, 1'b0, 3'b101, 32'h12, 32'h0, 32'h0000CAFE, 1'b0);
        lit("w0_lh_12", 1, 1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFCAFE, 1'b0);
        txn(1, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat, a0);
        txn(1, 1'b0, 3'b010, 32'h14, 32'h0, 0, rd, er, lat, a1);
        txn(1, 1'b0, 3'b010, 32'h18, 32'h0, 0, rd, er, lat, a2);
        chk("b2b_spacing_1", 1, 32'(a1 - a0), 32'd2);
        chk("b2b_spacing_2", 1, 32'(a2 - a1), 32'd2);

        // Randomized traffic with backpressure, checked by the compare process
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 300; n++) begin
                if ($urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 4))
                        0: f3 = 3'b000;
                        1: f3 = 3'b001;
                        2: f3 = 3'b010;
                        3: f3 = 3'b100;
                        default: f3 = 3'b101;
                    endcase
                end else begin
                    f3 = 3'($urandom);
                end
                a = 32'($urandom_range(0, DEPTH + 7)) * 4 + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
                if ($urandom_range(0, 31) == 0) a = $urandom;
                txn(k, 1'($urandom_range(0, 1)), f3, a, $urandom,
                    ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)), rd, er, lat, a0);
            end
        end

        repeat (2) @(posedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
